keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad and synchronizes and debounces the row returns.
- Decodes each accepted press to a 4-bit hex code.
- Keeps the last two accepted digits. These feed the i0/i1 inputs of the time-multiplexed dual seven-segment display stage directly downstream.
- Exactly one press is registered per physical press-and-release.

Parameters:
- SCAN_DIV, 12000, clk cycles each column is driven before advancing (250 us at 48 MHz); must be >= 4.
- DEBOUNCE_CYCLES, 240000, consecutive stable cycles required to accept a press or a release (5 ms at 48 MHz); must be >= 2.

Ports:
- clk  in  1  system clock (HSOSC int_osc).
- reset  in  1  asynchronous, active-low reset.
- rows  in  4  keypad row returns; asynchronous, active-low, externally pulled up.
- cols  out  4  column drive; active-low one-hot.
- key_code  out  4  hex code of the most recently accepted key.
- key_valid  out  1  one-cycle pulse when a key is accepted.
- digit_new  out  4  most recent accepted digit (to display i0).
- digit_old  out  4  previous accepted digit (to display i1).
- scanning  out  1  high while in state SCAN.

Behaviour:
- Reset (reset=0, async), values held until the first clk edge after release:
  - cols=4'b1110, key_code=0, key_valid=0, digit_new=0, digit_old=0, scanning=1.
  - State SCAN, all counters 0.
- Synchronizer: rows pass through 2 flops before any use, giving rows_s. All timing below refers to rows_s.
- SCAN:
  - cols rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV cycles.
  - Rows are sampled on the last dwell cycle of each column only, leaving settling time.
  - If any rows_s bit is 0 at that sample: latch the column index and the lowest-index low row, freeze cols, go to DEBOUNCE with the counter cleared.
- DEBOUNCE:
  - The counter increments each cycle the latched row is low.
  - If the latched row reads 1 before expiry: return to SCAN, resuming at the next column.
  - On expiry (counter == DEBOUNCE_CYCLES-1 with the row still low), in the same cycle:
    - key_code <= decode(row, col); key_valid <= 1 for one cycle.
    - digit_old <= digit_new; digit_new <= decode(row, col).
    - Go to HELD.
- HELD:
  - cols stays frozen. Other keys are ignored, including other rows in the same column.
  - When the latched row reads 1, go to RELEASE with the counter cleared.
- RELEASE:
  - The counter increments each cycle the row is high.
  - Any low sample returns to HELD; this is bounce, not a new press.
  - On expiry go to SCAN at the next column.
- Key accept latency: rows edge -> key_valid = 2 sync cycles + wait to the sample point + DEBOUNCE_CYCLES.
- Decode, row r / col c, 0-indexed:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Boundaries:
  - Counter and column index wrap modulo their range.
  - Reset mid-DEBOUNCE or mid-HELD discards the press with no key_valid.
  - A press held across reset release is treated as a new press.

Optional Feature:
- Macro KEYPAD_GHOST_REJECT_EN.
- Defined:
  - In SCAN, a sample with more than one low row is ignored.
  - In DEBOUNCE, more than one low row aborts to SCAN.
  - Multi-key presses never register.
- Undefined: the lowest-index low row wins, as described in Behaviour.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - the 16-entry key decode constant array indexed {row, col};
  - the column drive constant array.
- Counter widths are derived locally with $clog2 of the parameters.
- Sub-module sync_2ff (parameterized width) is the row synchronizer.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
1. Reset then idle with rows=1111 -> cols cycles 1110, 1101, 1011, 0111 every 4 clk; key_valid never asserts; digits stay 0.
2. Hold row1 low while col2 is driven, for 20 cycles, then release -> exactly one key_valid pulse; key_code=4'h6; digit_new=6, digit_old=0; scanning returns to 1 after release debounce.
3. Press 5 then 9, each fully released -> digit_new=9, digit_old=5; two key_valid pulses total.
4. Row0 bounces in col0 (low 3 cycles, high 1, repeat) -> no key_valid; FSM returns to SCAN. Then row0 held low for 12 stable cycles -> key_code=1.
5. Key held for 100 cycles with 2-cycle release glitches mid-hold -> a single key_valid.
6. Rows 0 and 2 low together in col1:
   - without the macro -> key_code=2;
   - with KEYPAD_GHOST_REJECT_EN -> no key_valid.
   Also: reset asserted during DEBOUNCE -> outputs return to reset values immediately with no pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, decode tables and row helpers for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  // Indexed {row, col}; row 3 follows the physical keypad legend, not hex order.
  localparam logic [3:0] KEY_DECODE [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic multi_low(input logic [3:0] r);
    logic [3:0] act;
    act = ~r;
    return (act & (act - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and two-digit history.
// Define KEYPAD_GHOST_REJECT_EN to reject samples with more than one low row.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 12000,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       scanning
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  state_t        state;
  logic [SW-1:0] scan_cnt;
  logic [DW-1:0] deb_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    row_idx;
  logic [3:0]    rows_s;
  logic [1:0]    next_col;
  logic          row_low;
  logic          any_low;
  logic          multi;
  logic [3:0]    decoded;

  sync_2ff #(.WIDTH(4), .RESET_VALUE(4'hF)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign next_col = col_idx + 2'd1;
  assign row_low  = ~rows_s[row_idx];
  assign any_low  = ~&rows_s;
  assign decoded  = KEY_DECODE[{row_idx, col_idx}];

`ifdef KEYPAD_GHOST_REJECT_EN
  assign multi = multi_low(rows_s);
`else
  assign multi = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      col_idx   <= 2'd0;
      row_idx   <= 2'd0;
      cols      <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
      scanning  <= 1'b1;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          // Sample only on the last dwell cycle so the rows have settled.
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (any_low && !multi) begin
              row_idx  <= low_row(rows_s);
              deb_cnt  <= '0;
              state    <= DEBOUNCE;
              scanning <= 1'b0;
            end else begin
              col_idx <= next_col;
              cols    <= COL_DRIVE[next_col];
            end
          end else begin
            scan_cnt <= scan_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!row_low || multi) begin
            state    <= SCAN;
            scanning <= 1'b1;
            scan_cnt <= '0;
            col_idx  <= next_col;
            cols     <= COL_DRIVE[next_col];
          end else if (deb_cnt == DEB_LAST) begin
            key_code  <= decoded;
            key_valid <= 1'b1;
            digit_old <= digit_new;
            digit_new <= decoded;
            state     <= HELD;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!row_low) begin
            deb_cnt <= '0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          // A low sample here is release bounce, so fall back to HELD.
          if (row_low) begin
            state <= HELD;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= SCAN;
            scanning <= 1'b1;
            scan_cnt <= '0;
            col_idx  <= next_col;
            cols     <= COL_DRIVE[next_col];
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state    <= SCAN;
          scanning <= 1'b1;
        end
      endcase
    end
  end

endmodule
